lsu_ifu_mem_arbiter: RTL
========================

LSU_IFU_MEM_ARBITER -- requirements
Module: lsu_ifu_mem_arbiter

Interface
REQ-001 Parameter FAIR, default 1: 1 = alternating priority on contention; 0 = LSU always wins.
REQ-002 The block SHALL have one clock and one reset: clk, rst; rst SHALL be asynchronous and active-low.
REQ-003 Ports SHALL be (name  direction  width  meaning):
 clk  in  1  clock
 rst  in  1  async active-low reset
 ifu_req_valid  in  1  fetch request
 ifu_req_ready  out  1  fetch request accepted
 ifu_addr  in  `RegWidth  fetch address
 ifu_resp_valid  out  1  fetch data valid
 ifu_resp_ready  in  1  IFU accepts data
 ifu_resp_data  out  `RegWidth  fetch data
 ifu_flush  in  1  discard in-flight fetch
 lsu_req_valid  in  1  load/store request
 lsu_req_ready  out  1  LSU request accepted
 lsu_addr  in  `RegWidth  access address
 lsu_wen  in  1  1 = store
 lsu_wdata  in  `RegWidth  store data
 lsu_wmask  in  8  byte strobes
 lsu_resp_valid  out  1  load data / store ack valid
 lsu_resp_ready  in  1  LSU accepts response
 lsu_resp_data  out  `RegWidth  load data
 mem_req_valid  out  1  bus request
 mem_req_ready  in  1  bus accepts request
 mem_addr, mem_wdata  out  `RegWidth  registered address/data
 mem_wen  out  1  registered write enable
 mem_wmask  out  8  registered strobes (0 for IFU)
 mem_resp_valid  in  1  bus response
 mem_resp_ready  out  1  response accepted
 mem_resp_data  in  `RegWidth  bus read data

Function
REQ-004 FSM states: IDLE, REQ, RESP; exactly one transaction outstanding.
REQ-005 IDLE: if any req_valid, winner's req_ready=1 combinationally; winner's addr/wen/wdata/wmask latched into mem_* registers, owner register set; -> REQ next cycle. Loser's req_ready=0.
REQ-006 Arbitration on simultaneous requests: FAIR=1 -> grant the requester not granted last (last_grant resets to IFU, so LSU wins first contention); FAIR=0 -> LSU. Single requester always granted.
REQ-007 req_ready SHALL be 0 in REQ and RESP.
REQ-008 REQ: mem_req_valid=1, mem_* stable; on mem_req_ready -> RESP.
REQ-009 RESP: mem_resp_ready = owner's resp_ready; owner's resp_valid = mem_resp_valid; resp_data = mem_resp_data; non-owner resp_valid=0. On mem_resp_valid && mem_resp_ready -> IDLE.
REQ-010 Minimum latency: grant cycle N, mem_req_valid cycle N+1, earliest response forwarded N+2.
REQ-011 ifu_flush while owner=IFU in REQ or RESP (or same cycle as IFU grant) SHALL set drop flag; with drop set, ifu_resp_valid=0 and mem_resp_ready=1; flag cleared on return to IDLE. Bus request is never withdrawn.
REQ-012 ifu_flush with owner=LSU or in IDLE without IFU grant SHALL have no effect.
REQ-013 Stores: lsu_resp_valid asserted on bus write ack; lsu_resp_data undefined.
REQ-014 mem_resp_valid in IDLE/REQ SHALL be ignored (mem_resp_ready=0).

Reset
REQ-015 rst low SHALL immediately force: state IDLE, mem_req_valid=0, mem_resp_ready=0, all resp_valid=0, drop=0, last_grant=IFU, mem_addr/wdata/wen/wmask=0.
REQ-016 Reset mid-transaction abandons it; no response forwarded after rst release.

Structure
REQ-017 FSM state encoding and owner encoding (IFU=0, LSU=1) SHALL live in the shared defines file alongside `RegWidth.
REQ-018 Single module; mem_* capture SHALL use the existing Reg sub-module with wen = grant.

Verification
REQ-019 Only IFU req addr 0x80000000, mem ready immediately, resp 0x00000413 next cycle -> ifu_resp_valid at N+2 with 0x00000413.
REQ-020 IFU and LSU request same cycle, FAIR=1, after reset -> LSU granted; both again -> IFU granted; FAIR=0 -> LSU both times.
REQ-021 LSU store addr 0x80001000, wdata 0x1122334455667788, wmask 0xFF, mem_req_ready held 0 for 3 cycles -> mem_* stable all 3 cycles, lsu_resp_valid on ack.
REQ-022 IFU fetch in RESP, ifu_flush pulsed, bus returns 0xDEADBEEF -> ifu_resp_valid stays 0, mem_resp_ready=1, next IFU request granted.
REQ-023 lsu_resp_ready=0 for 2 cycles while mem_resp_valid=1 -> state held RESP, data stable, transfer on third cycle.
REQ-024 rst low during REQ -> mem_req_valid 0 in same cycle; after release state IDLE, no stray resp_valid.

Source files
------------

// File: rtl/lsu_ifu_mem_arbiter_pkg.sv
// Shared types for the LSU/IFU memory arbiter: FSM and owner encodings, bus widths, captured command.
// Pure declarations; no latency or flow control of its own.
package lsu_ifu_mem_arbiter_pkg;

    localparam int REG_WIDTH  = 64;
    localparam int MASK_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    typedef enum logic {
        OWN_IFU = 1'b0,
        OWN_LSU = 1'b1
    } owner_t;

    typedef struct packed {
        logic [REG_WIDTH-1:0]  addr;
        logic [REG_WIDTH-1:0]  wdata;
        logic                  wen;
        logic [MASK_WIDTH-1:0] wmask;
    } mem_cmd_t;

endpackage

// File: rtl/lsu_ifu_mem_arbiter_reg.sv
// Enable-gated register with asynchronous active-low clear; one cycle from wen to q.
// No flow control: q holds until the next enabled write.
module lsu_ifu_mem_arbiter_reg #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wen,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= '0;
        end else if (wen) begin
            q <= d;
        end
    end

endmodule

// File: rtl/lsu_ifu_mem_arbiter.sv
// Arbitrates IFU fetches and LSU accesses onto one memory bus, one transaction outstanding.
// Grant at N, bus request from N+1, response forwarded from N+2; all stalls via valid/ready.
module lsu_ifu_mem_arbiter
    import lsu_ifu_mem_arbiter_pkg::*;
#(
    parameter bit FAIR = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ifu_req_valid,
    output logic                  ifu_req_ready,
    input  logic [REG_WIDTH-1:0]  ifu_addr,
    output logic                  ifu_resp_valid,
    input  logic                  ifu_resp_ready,
    output logic [REG_WIDTH-1:0]  ifu_resp_data,
    input  logic                  ifu_flush,
    input  logic                  lsu_req_valid,
    output logic                  lsu_req_ready,
    input  logic [REG_WIDTH-1:0]  lsu_addr,
    input  logic                  lsu_wen,
    input  logic [REG_WIDTH-1:0]  lsu_wdata,
    input  logic [MASK_WIDTH-1:0] lsu_wmask,
    output logic                  lsu_resp_valid,
    input  logic                  lsu_resp_ready,
    output logic [REG_WIDTH-1:0]  lsu_resp_data,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic [REG_WIDTH-1:0]  mem_addr,
    output logic [REG_WIDTH-1:0]  mem_wdata,
    output logic                  mem_wen,
    output logic [MASK_WIDTH-1:0] mem_wmask,
    input  logic                  mem_resp_valid,
    output logic                  mem_resp_ready,
    input  logic [REG_WIDTH-1:0]  mem_resp_data
);

    state_t   state;
    state_t   state_nxt;
    owner_t   owner;
    logic     drop;
    logic     grant;
    logic     lsu_win;
    logic     ifu_win;
    logic     resp_fire;
    mem_cmd_t cmd_d;
    mem_cmd_t cmd_q;

    // owner doubles as the last-granted requester for fair arbitration
    always_comb begin
        grant   = (state == ST_IDLE) && (ifu_req_valid || lsu_req_valid);
        lsu_win = grant && lsu_req_valid &&
                  (!ifu_req_valid || !FAIR || (owner == OWN_IFU));
        ifu_win = grant && !lsu_win;

        cmd_d = '0;
        if (lsu_win) begin
            cmd_d.addr  = lsu_addr;
            cmd_d.wdata = lsu_wdata;
            cmd_d.wen   = lsu_wen;
            cmd_d.wmask = lsu_wmask;
        end else begin
            cmd_d.addr  = ifu_addr;
        end
    end

    lsu_ifu_mem_arbiter_reg #(
        .WIDTH ($bits(mem_cmd_t))
    ) u_cmd_reg (
        .clk (clk),
        .rst (rst),
        .wen (grant),
        .d   (cmd_d),
        .q   (cmd_q)
    );

    assign mem_addr  = cmd_q.addr;
    assign mem_wdata = cmd_q.wdata;
    assign mem_wen   = cmd_q.wen;
    assign mem_wmask = cmd_q.wmask;

    assign resp_fire = (state == ST_RESP) && mem_resp_valid && mem_resp_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (grant)         state_nxt = ST_REQ;
            ST_REQ:  if (mem_req_ready) state_nxt = ST_RESP;
            ST_RESP: if (resp_fire)     state_nxt = ST_IDLE;
            default:                    state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        ifu_req_ready  = ifu_win;
        lsu_req_ready  = lsu_win;
        mem_req_valid  = (state == ST_REQ);
        mem_resp_ready = 1'b0;
        ifu_resp_valid = 1'b0;
        lsu_resp_valid = 1'b0;
        if (state == ST_RESP) begin
            if (owner == OWN_LSU) begin
                mem_resp_ready = lsu_resp_ready;
                lsu_resp_valid = mem_resp_valid;
            end else if (drop) begin
                mem_resp_ready = 1'b1;
            end else begin
                mem_resp_ready = ifu_resp_ready;
                ifu_resp_valid = mem_resp_valid;
            end
        end
    end

    assign ifu_resp_data = mem_resp_data;
    assign lsu_resp_data = mem_resp_data;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner <= OWN_IFU;
        end else if (grant) begin
            owner <= lsu_win ? OWN_LSU : OWN_IFU;
        end
    end

    // A flushed fetch still completes on the bus; its response is sunk here.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            drop <= 1'b0;
        end else if (resp_fire) begin
            drop <= 1'b0;
        end else if (ifu_flush && (ifu_win || ((state != ST_IDLE) && (owner == OWN_IFU)))) begin
            drop <= 1'b1;
        end
    end

endmodule
